// File: rtl/adder_pkg.sv
// Shared types and helpers for the serial add/subtract unit.
package adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Ceiling log2, usable in constant expressions for counter sizing.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder; DIGIT copies form the per-cycle ripple slice.
module fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle add/subtract: DIGIT bits per clock, LSB first, registered carry,
// valid/ready on both operand and result sides.
module serial_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned STEPS = WIDTH / DIGIT;
  localparam int unsigned CW    = clog2(STEPS) + 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    count_q, count_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic [DIGIT:0]   c;
  logic [DIGIT-1:0] s_digit;

  // Ripple slice over the low DIGIT bits of the operand shift registers.
  assign c[0] = carry_q;
  for (genvar i = 0; i < DIGIT; i++) begin : g_slice
    fa_cell u_fa (
      .a_i (a_sr_q[i]),
      .b_i (b_sr_q[i]),
      .c_i (c[i]),
      .s_o (s_digit[i]),
      .c_o (c[i+1])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_sr_q      <= '0;
      b_sr_q      <= '0;
      sum_q       <= '0;
      count_q     <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sr_q      <= a_sr_d;
      b_sr_q      <= b_sr_d;
      sum_q       <= sum_d;
      count_q     <= count_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    sum_d   = sum_q;
    count_d = count_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          a_sr_d  = a;
          b_sr_d  = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          count_d = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        a_sr_d  = a_sr_q >> DIGIT;
        b_sr_d  = b_sr_q >> DIGIT;
        sum_d   = (sum_q >> DIGIT) | (WIDTH'(s_digit) << (WIDTH - DIGIT));
        carry_d = c[DIGIT];
        count_d = count_q + CW'(1);
        // Last slice holds the MSB: its carry-in vs carry-out gives signed overflow.
        if (count_q == CW'(STEPS - 1)) begin
          cout_d  = c[DIGIT];
          ovf_d   = c[DIGIT] ^ c[DIGIT-1];
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench: an 8-bit/1-digit and a 16-bit/4-digit instance checked
// against an arithmetic reference model.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       rst8, in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8;
  logic       cout8, ovf8, busy8;
  logic [7:0] a8, b8, sum8;

  logic        rst16, in_valid16, in_ready16, cin16, sub16, out_valid16, out_ready16;
  logic        cout16, ovf16, busy16;
  logic [15:0] a16, b16, sum16;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u8 (
    .clk(clk), .rst(rst8), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8), .ovf(ovf8), .busy(busy8)
  );

  serial_adder #(.WIDTH(16), .DIGIT(4)) u16 (
    .clk(clk), .rst(rst16), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .cin(cin16), .sub(sub16),
    .out_valid(out_valid16), .out_ready(out_ready16),
    .sum(sum16), .cout(cout16), .ovf(ovf16), .busy(busy16)
  );

  // Reference: {ovf, cout, sum} from plain w-bit two's-complement arithmetic.
  function automatic logic [17:0] ref_op(input int unsigned w, input logic [15:0] ra,
                                         input logic [15:0] rb, input logic rcin,
                                         input logic rsub);
    longint unsigned mask, av, bv, full, s;
    logic            c, o, sa, sb, ss;
    mask = (64'd1 << w) - 64'd1;
    av   = 64'(ra) & mask;
    bv   = 64'(rsub ? ~rb : rb) & mask;
    full = av + bv + 64'(rsub ? 1'b1 : rcin);
    s    = full & mask;
    c    = ((full >> w) & 64'd1) != 64'd0;
    sa   = ((av >> (w - 1)) & 64'd1) != 64'd0;
    sb   = ((bv >> (w - 1)) & 64'd1) != 64'd0;
    ss   = ((s >> (w - 1)) & 64'd1) != 64'd0;
    o    = (sa == sb) && (ss != sa);
    return {o, c, 16'(s)};
  endfunction

  task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tcin,
                     input logic tsub, input logic [7:0] es, input logic ec,
                     input logic eo, input int rdly, input logic poke,
                     input string name);
    int cyc;
    cyc = 0;
    while (!in_ready8 && cyc < 40) begin @(posedge clk); #1; cyc++; end
    a8 = ta; b8 = tb; cin8 = tcin; sub8 = tsub; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sub8 = ~tsub;
    cyc = 0;
    while (!out_valid8 && cyc < 40) begin @(posedge clk); #1; cyc++; end
    checks++;
    if (cyc !== 8) begin
      $display("FAIL %s latency: got %0d cycles, expected 8", name, cyc); errors++;
    end
    checks++;
    if ({sum8, cout8, ovf8} !== {es, ec, eo}) begin
      $display("FAIL %s result: got sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
               name, sum8, cout8, ovf8, es, ec, eo); errors++;
    end
    for (int k = 0; k < rdly; k++) begin
      in_valid8 = poke & k[0]; a8 = 8'($urandom); b8 = 8'($urandom);
      @(posedge clk); #1;
      checks++;
      if ({out_valid8, in_ready8, sum8, cout8, ovf8} !== {1'b1, 1'b0, es, ec, eo}) begin
        $display("FAIL %s hold[%0d]: got ov=%b ir=%b sum=%h cout=%b ovf=%b, expected ov=1 ir=0 sum=%h cout=%b ovf=%b",
                 name, k, out_valid8, in_ready8, sum8, cout8, ovf8, es, ec, eo); errors++;
      end
    end
    in_valid8 = 1'b0; out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    checks++;
    if ({out_valid8, in_ready8, busy8, sum8} !== {1'b0, 1'b1, 1'b0, es}) begin
      $display("FAIL %s release: got ov=%b ir=%b busy=%b sum=%h, expected ov=0 ir=1 busy=0 sum=%h",
               name, out_valid8, in_ready8, busy8, sum8, es); errors++;
    end
  endtask

  task automatic op16(input logic [15:0] ta, input logic [15:0] tb, input logic tcin,
                      input logic tsub, input logic [15:0] es, input logic ec,
                      input logic eo, input int rdly, input string name);
    int cyc;
    cyc = 0;
    while (!in_ready16 && cyc < 40) begin @(posedge clk); #1; cyc++; end
    a16 = ta; b16 = tb; cin16 = tcin; sub16 = tsub; in_valid16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
    cyc = 0;
    while (!out_valid16 && cyc < 40) begin @(posedge clk); #1; cyc++; end
    checks++;
    if (cyc !== 4) begin
      $display("FAIL %s latency: got %0d cycles, expected 4", name, cyc); errors++;
    end
    checks++;
    if ({sum16, cout16, ovf16} !== {es, ec, eo}) begin
      $display("FAIL %s result a=%h b=%h cin=%b sub=%b: got sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
               name, ta, tb, tcin, tsub, sum16, cout16, ovf16, es, ec, eo); errors++;
    end
    repeat (rdly) begin @(posedge clk); #1; end
    out_ready16 = 1'b1;
    @(posedge clk); #1;
    out_ready16 = 1'b0;
  endtask

  task automatic test_reset();
    rst8 = 1'b1; rst16 = 1'b1;
    in_valid8 = 0; a8 = 0; b8 = 0; cin8 = 0; sub8 = 0; out_ready8 = 0;
    in_valid16 = 0; a16 = 0; b16 = 0; cin16 = 0; sub16 = 0; out_ready16 = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready8, out_valid8, busy8, sum8, cout8, ovf8} !== {3'b100, 8'h00, 2'b00}) begin
      $display("FAIL reset8: got ir=%b ov=%b busy=%b sum=%h cout=%b ovf=%b",
               in_ready8, out_valid8, busy8, sum8, cout8, ovf8); errors++;
    end
    checks++;
    if ({in_ready16, out_valid16, busy16, sum16, cout16, ovf16} !== {3'b100, 16'h0000, 2'b00}) begin
      $display("FAIL reset16: got ir=%b ov=%b busy=%b sum=%h cout=%b ovf=%b",
               in_ready16, out_valid16, busy16, sum16, cout16, ovf16); errors++;
    end
    rst8 = 1'b0; rst16 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    op8(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, 0, 1'b0, "add_5a_3c");
    op8(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, "add_ff_01");
    op8(8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1, 0, 1'b0, "add_7f_cin");
    op8(8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0, 0, 1'b0, "sub_10_20");
    op8(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 0, 1'b0, "sub_80_01");
  endtask

  task automatic test_backpressure();
    op8(8'hC3, 8'h55, 1'b1, 1'b0, 8'h19, 1'b1, 1'b0, 5, 1'b1, "backpressure");
  endtask

  task automatic test_reset_mid();
    logic seen;
    a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b0; sub8 = 1'b0; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (busy8 !== 1'b1) begin
      $display("FAIL reset_mid precondition: busy got %b, expected 1", busy8); errors++;
    end
    rst8 = 1'b1;
    #1;
    checks++;
    if ({in_ready8, out_valid8, busy8, sum8, cout8, ovf8} !== {3'b100, 8'h00, 2'b00}) begin
      $display("FAIL reset_mid outputs: got ir=%b ov=%b busy=%b sum=%h cout=%b ovf=%b",
               in_ready8, out_valid8, busy8, sum8, cout8, ovf8); errors++;
    end
    #2 rst8 = 1'b0;
    seen = 1'b0;
    repeat (12) begin @(posedge clk); #1; if (out_valid8) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0) begin
      $display("FAIL reset_mid pulse: out_valid got 1 after abort, expected 0"); errors++;
    end
    op8(8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 0, 1'b0, "reset_recover");
  endtask

  task automatic test_random8();
    logic [17:0] r;
    logic [7:0]  ra, rb;
    logic        rc, rs;
    for (int i = 0; i < 100; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      r  = ref_op(8, {8'h00, ra}, {8'h00, rb}, rc, rs);
      op8(ra, rb, rc, rs, r[7:0], r[16], r[17], int'($urandom_range(0, 2)), 1'b1, "rand8");
    end
  endtask

  task automatic test_wide();
    logic [17:0] r;
    logic [15:0] ra, rb;
    logic        rc, rs;
    op16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0, "wide_ffff_0001");
    op16(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1, "wide_sub_ovf");
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      r  = ref_op(16, ra, rb, rc, rs);
      op16(ra, rb, rc, rs, r[15:0], r[16], r[17], int'($urandom_range(0, 2)), "rand16");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random8();
    test_wide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
